carry4_alu2_arbiter: RTL and testbench

CARRY4_ALU2_ARBITER -- requirements
Module: carry4_alu2_arbiter

---
 rtl/carry4_alu2_arbiter.sv | 242 ++++++++++++++++++++++++
 tb/tb_carry4_alu2_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/carry4_alu2_arbiter.sv
// Round-robin arbiter that serialises NREQ requesters onto one shared ALU, one job in flight.
// Optional per-requester carry chaining is enabled with `define CARRY4_ALU2_ARB_CHAIN_EN.
module carry4_alu2_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [3*NREQ-1:0] req_opcode,
    input  logic [8*NREQ-1:0] req_operand0,
    input  logic [8*NREQ-1:0] req_operand1,
    input  logic [NREQ-1:0]   req_carry,
    output logic [NREQ-1:0]   req_grant,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [7:0]        rsp_result,
    output logic              rsp_carry,
    output logic              rsp_zero,
    output logic              rsp_sign,
    output logic              rsp_error,
    output logic              alu_enable,
    output logic              alu_write,
    output logic              alu_strobe,
    output logic              alu_carryflag,
    output logic [2:0]        alu_opcode,
    output logic [7:0]        alu_operand0,
    output logic [7:0]        alu_operand1,
    input  logic [7:0]        alu_result,
    input  logic              alu_carryflag_in,
    input  logic              alu_zeroflag,
    input  logic              alu_signflag,
    input  logic              alu_ready
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_e;

    state_e            state_q;
    logic [IW-1:0]     ptr_q;
    logic [IW-1:0]     ptr_d;
    logic [7:0]        cnt_q;
    logic [7:0]        cnt_d;
    logic              armed_q;
    logic [IW-1:0]     job_idx_q;

    logic              alu_enable_q;
    logic              alu_write_q;
    logic              alu_strobe_q;
    logic              alu_carryflag_q;
    logic [2:0]        alu_opcode_q;
    logic [7:0]        alu_operand0_q;
    logic [7:0]        alu_operand1_q;

    logic [NREQ-1:0]   rsp_valid_q;
    logic [7:0]        rsp_result_q;
    logic              rsp_carry_q;
    logic              rsp_zero_q;
    logic              rsp_sign_q;
    logic              rsp_error_q;

    logic              hit_hi;
    logic [IW-1:0]     idx_hi;
    logic [IW-1:0]     idx_any;
    logic [IW-1:0]     gnt_idx;
    logic              grant_fire;
    logic              timeout_hit;

    logic [2:0]        sel_opcode;
    logic [7:0]        sel_operand0;
    logic [7:0]        sel_operand1;
    logic              sel_carry_in;
    logic              carry_d;

    // Round-robin: lowest requesting index at or above ptr wins, else lowest index overall.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        hit_hi  = 1'b0;
        idx_hi  = '0;
        idx_any = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                idx_any = IW'(i);
                if (IW'(i) >= ptr_q) begin
                    hit_hi = 1'b1;
                    idx_hi = IW'(i);
                end
            end
        end
        gnt_idx = hit_hi ? idx_hi : idx_any;
        ptr_d   = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

    always_comb begin
        sel_opcode   = '0;
        sel_operand0 = '0;
        sel_operand1 = '0;
        sel_carry_in = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IW'(i)) begin
                sel_opcode   = req_opcode[3*i +: 3];
                sel_operand0 = req_operand0[8*i +: 8];
                sel_operand1 = req_operand1[8*i +: 8];
                sel_carry_in = req_carry[i];
            end
        end
    end

`ifdef CARRY4_ALU2_ARB_CHAIN_EN
    logic [NREQ-1:0] chain_q;
    logic            sel_chain;

    always_comb begin
        sel_chain = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IW'(i)) begin
                sel_chain = chain_q[i];
            end
        end
    end

    assign carry_d = sel_carry_in & sel_chain;

    // Only a clean completion carries forward; timeouts leave the requester's carry untouched.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            chain_q <= '0;
        end else if (state_q == WAIT && alu_ready) begin
            chain_q[job_idx_q] <= alu_carryflag_in;
        end
    end
`else
    assign carry_d = sel_carry_in;
`endif

    // armed_q keeps the grant low until the first clock edge after reset release.
    assign grant_fire  = (state_q == IDLE) && armed_q && (|req_valid);
    assign cnt_d       = cnt_q + 8'd1;
    assign timeout_hit = (cnt_d == 8'(TIMEOUT));

    // The grant is a same-cycle accept pulse, so it is decoded from state rather than registered.
    assign req_grant = grant_fire ? (ONE_HOT0 << gnt_idx) : '0;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q         <= IDLE;
            ptr_q           <= '0;
            cnt_q           <= '0;
            armed_q         <= 1'b0;
            job_idx_q       <= '0;
            alu_enable_q    <= 1'b0;
            alu_write_q     <= 1'b0;
            alu_strobe_q    <= 1'b0;
            alu_carryflag_q <= 1'b0;
            alu_opcode_q    <= '0;
            alu_operand0_q  <= '0;
            alu_operand1_q  <= '0;
            rsp_valid_q     <= '0;
            rsp_result_q    <= '0;
            rsp_carry_q     <= 1'b0;
            rsp_zero_q      <= 1'b0;
            rsp_sign_q      <= 1'b0;
            rsp_error_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples pre-edge values regardless of statement order.
            armed_q      <= 1'b1;
            alu_write_q  <= 1'b0;
            alu_strobe_q <= 1'b0;
            rsp_valid_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (grant_fire) begin
                        state_q         <= ISSUE;
                        ptr_q           <= ptr_d;
                        job_idx_q       <= gnt_idx;
                        alu_opcode_q    <= sel_opcode;
                        alu_operand0_q  <= sel_operand0;
                        alu_operand1_q  <= sel_operand1;
                        alu_carryflag_q <= carry_d;
                        alu_enable_q    <= 1'b1;
                        alu_write_q     <= 1'b1;
                        alu_strobe_q    <= 1'b1;
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                    cnt_q   <= '0;
                end
                WAIT: begin
                    if (alu_ready) begin
                        state_q      <= DONE;
                        alu_enable_q <= 1'b0;
                        rsp_valid_q  <= ONE_HOT0 << job_idx_q;
                        rsp_result_q <= alu_result;
                        rsp_carry_q  <= alu_carryflag_in;
                        rsp_zero_q   <= alu_zeroflag;
                        rsp_sign_q   <= alu_signflag;
                        rsp_error_q  <= 1'b0;
                    end else if (timeout_hit) begin
                        state_q      <= DONE;
                        alu_enable_q <= 1'b0;
                        rsp_valid_q  <= ONE_HOT0 << job_idx_q;
                        rsp_result_q <= 8'h00;
                        rsp_carry_q  <= 1'b0;
                        rsp_zero_q   <= 1'b0;
                        rsp_sign_q   <= 1'b0;
                        rsp_error_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_result    = rsp_result_q;
    assign rsp_carry     = rsp_carry_q;
    assign rsp_zero      = rsp_zero_q;
    assign rsp_sign      = rsp_sign_q;
    assign rsp_error     = rsp_error_q;
    assign alu_enable    = alu_enable_q;
    assign alu_write     = alu_write_q;
    assign alu_strobe    = alu_strobe_q;
    assign alu_carryflag = alu_carryflag_q;
    assign alu_opcode    = alu_opcode_q;
    assign alu_operand0  = alu_operand0_q;
    assign alu_operand1  = alu_operand1_q;

endmodule

// File: tb/tb_carry4_alu2_arbiter.sv
// Directed bench for carry4_alu2_arbiter: latency, round-robin order, timeout, reset abandon, carry handling.
module tb_carry4_alu2_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 15;

    logic              aclk;
    logic              aresetn;
    logic [NREQ-1:0]   req_valid;
    logic [3*NREQ-1:0] req_opcode;
    logic [8*NREQ-1:0] req_operand0;
    logic [8*NREQ-1:0] req_operand1;
    logic [NREQ-1:0]   req_carry;
    logic [NREQ-1:0]   req_grant;
    logic [NREQ-1:0]   rsp_valid;
    logic [7:0]        rsp_result;
    logic              rsp_carry, rsp_zero, rsp_sign, rsp_error;
    logic              alu_enable, alu_write, alu_strobe, alu_carryflag;
    logic [2:0]        alu_opcode;
    logic [7:0]        alu_operand0, alu_operand1;
    logic [7:0]        alu_result;
    logic              alu_carryflag_in, alu_zeroflag, alu_signflag, alu_ready;

    int n_tests  = 0;
    int n_failed = 0;

    logic [2:0] opc_m [NREQ];
    logic [7:0] a_m   [NREQ];
    logic [7:0] b_m   [NREQ];
    logic       cin_m [NREQ];
    logic       chain_m [NREQ];

    carry4_alu2_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .req_valid        (req_valid),
        .req_opcode       (req_opcode),
        .req_operand0     (req_operand0),
        .req_operand1     (req_operand1),
        .req_carry        (req_carry),
        .req_grant        (req_grant),
        .rsp_valid        (rsp_valid),
        .rsp_result       (rsp_result),
        .rsp_carry        (rsp_carry),
        .rsp_zero         (rsp_zero),
        .rsp_sign         (rsp_sign),
        .rsp_error        (rsp_error),
        .alu_enable       (alu_enable),
        .alu_write        (alu_write),
        .alu_strobe       (alu_strobe),
        .alu_carryflag    (alu_carryflag),
        .alu_opcode       (alu_opcode),
        .alu_operand0     (alu_operand0),
        .alu_operand1     (alu_operand1),
        .alu_result       (alu_result),
        .alu_carryflag_in (alu_carryflag_in),
        .alu_zeroflag     (alu_zeroflag),
        .alu_signflag     (alu_signflag),
        .alu_ready        (alu_ready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic [2:0] op, input logic [7:0] x,
                           input logic [7:0] y, input logic c);
        opc_m[idx] = op;
        a_m[idx]   = x;
        b_m[idx]   = y;
        cin_m[idx] = c;
        req_opcode[3*idx +: 3]   = op;
        req_operand0[8*idx +: 8] = x;
        req_operand1[8*idx +: 8] = y;
        req_carry[idx]           = c;
    endtask

    task automatic drive_junk();
        alu_result       = 8'hA5;
        alu_carryflag_in = 1'b1;
        alu_zeroflag     = 1'b1;
        alu_signflag     = 1'b1;
    endtask

    // One job: grant in cycle 0, strobe in cycle 1, ALU ready in cycle 1+d (d=0: never).
    task automatic run_job(input int idx, input int d, input bit early, input bit drop,
                           input logic [7:0] res, input logic [2:0] fl);
        int         got;
        bit         ok;
        logic       exp_cf;
        logic [31:0] exp_onehot;
        exp_onehot = 32'(1) << idx;
        ok = (d >= 1) && (d <= TIMEOUT);
`ifdef CARRY4_ALU2_ARB_CHAIN_EN
        exp_cf = cin_m[idx] & chain_m[idx];
`else
        exp_cf = cin_m[idx];
`endif
        @(negedge aclk); #1;
        check("grant", req_grant, exp_onehot);
        check("rsp_idle", rsp_valid, 0);

        @(negedge aclk);
        check("issue_grant_low", req_grant, 0);
        check("issue_strobe", {alu_enable, alu_write, alu_strobe}, 3'b111);
        check("issue_opcode", alu_opcode, opc_m[idx]);
        check("issue_operand0", alu_operand0, a_m[idx]);
        check("issue_operand1", alu_operand1, b_m[idx]);
        check("issue_carryflag", alu_carryflag, exp_cf);
        if (drop) req_valid[idx] = 1'b0;
        alu_ready = early;
        drive_junk();

        got = 0;
        for (int k = 2; k < 60; k++) begin
            @(negedge aclk);
            if (rsp_valid != '0) begin
                got = k;
                break;
            end
            if (k == 2) check("wait_strobe", {alu_enable, alu_write, alu_strobe}, 3'b100);
            alu_ready = (k == d + 1);
            if (alu_ready) begin
                alu_result = res;
                {alu_carryflag_in, alu_zeroflag, alu_signflag} = fl;
            end else begin
                drive_junk();
            end
        end
        alu_ready = 1'b0;

        check("rsp_latency", got, ok ? d + 2 : TIMEOUT + 2);
        check("rsp_valid", rsp_valid, exp_onehot);
        check("rsp_result", rsp_result, ok ? res : 8'h00);
        check("rsp_flags", {rsp_carry, rsp_zero, rsp_sign}, ok ? fl : 3'b000);
        check("rsp_error", rsp_error, !ok);
        check("done_enable", alu_enable, 0);
        if (ok) chain_m[idx] = fl[2];
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_grant"}, req_grant, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_alu_ctl"}, {alu_enable, alu_write, alu_strobe, alu_carryflag}, 0);
        check({tag, "_alu_data"}, {alu_opcode, alu_operand0, alu_operand1}, 0);
        check({tag, "_rsp_data"}, {rsp_result, rsp_carry, rsp_zero, rsp_sign, rsp_error}, 0);
    endtask

    initial begin
        aresetn      = 1'b0;
        req_valid    = '0;
        req_opcode   = '0;
        req_operand0 = '0;
        req_operand1 = '0;
        req_carry    = '0;
        alu_ready    = 1'b0;
        drive_junk();
        for (int i = 0; i < NREQ; i++) chain_m[i] = 1'b0;

        // Reset state, grant held off while in reset and until the first edge after release.
        set_req(0, 3'd0, 8'h12, 8'h34, 1'b0);
        @(negedge aclk);
        check_quiet("reset");
        req_valid = 4'b0001;
        #1 check("reset_grant_held", req_grant, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        #1 check("release_grant_held", req_grant, 0);

        // Single job, ALU ready two cycles after strobe: response in cycle 4.
        run_job(0, 2, 1'b0, 1'b1, 8'h46, 3'b000);

        // Carry-in set, ALU ready in first WAIT cycle, a ready during ISSUE must be ignored.
        set_req(3, 3'd5, 8'hFF, 8'h01, 1'b1);
        req_valid[3] = 1'b1;
        run_job(3, 1, 1'b1, 1'b1, 8'h00, 3'b110);

        // Fairness: all requesters held high for eight jobs.
        set_req(0, 3'd1, 8'h10, 8'h20, 1'b0);
        set_req(1, 3'd2, 8'h11, 8'h21, 1'b1);
        set_req(2, 3'd3, 8'h12, 8'h22, 1'b0);
        set_req(3, 3'd4, 8'h13, 8'h23, 1'b1);
        req_valid = 4'b1111;
        for (int j = 0; j < 8; j++) begin
            run_job(j % 4, 1 + (j % 3), 1'b0, 1'b0, 8'h30 + 8'(j), 3'(j));
        end
        req_valid = '0;

        // Timeout on requester 0, then requester 1 with ready on the last WAIT cycle.
        req_valid = 4'b0011;
        run_job(0, 0, 1'b0, 1'b1, 8'h00, 3'b000);
        run_job(1, TIMEOUT, 1'b0, 1'b1, 8'h5A, 3'b011);

        // Reset three cycles into WAIT abandons the job and clears the pointer.
        set_req(0, 3'd6, 8'h77, 8'h88, 1'b1);
        req_valid = 4'b0001;
        @(negedge aclk); #1;
        check("pre_reset_grant", req_grant, 1);
        @(negedge aclk);
        req_valid = '0;
        repeat (3) @(negedge aclk);
        #1 aresetn = 1'b0;
        #1 check_quiet("async_reset");
        for (int i = 0; i < NREQ; i++) chain_m[i] = 1'b0;
        req_valid = 4'b0011;
        repeat (3) begin
            @(negedge aclk);
            check("reset_hold_rsp", rsp_valid, 0);
            check("reset_hold_grant", req_grant, 0);
        end
        aresetn = 1'b1;
        #1 check("release2_grant_held", req_grant, 0);
        run_job(0, 3, 1'b0, 1'b1, 8'hC3, 3'b001);

        // Carry bookkeeping: requester 1 produces carry 1, requester 2 interleaves, requester 1 reuses it.
        set_req(1, 3'd0, 8'hF0, 8'h20, 1'b0);
        run_job(1, 2, 1'b0, 1'b1, 8'h10, 3'b100);
        set_req(2, 3'd0, 8'h01, 8'h02, 1'b1);
        req_valid[2] = 1'b1;
        run_job(2, 2, 1'b0, 1'b1, 8'h03, 3'b000);
        set_req(1, 3'd0, 8'h01, 8'h01, 1'b1);
        req_valid[1] = 1'b1;
        run_job(1, 2, 1'b0, 1'b1, 8'h03, 3'b000);

        @(negedge aclk);
        check("final_rsp_idle", rsp_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
